// File: rtl/row_sequencer_if.sv
// Bundle between the row-length FIFOs, the row sequencer and the element fetch /
// accumulator stages. master = sequencer side, slave = surrounding environment.
interface row_sequencer_if #(
  parameter int CHANNEL_NUM  = 8,
  parameter int ROW_LEN_SIZE = 9,
  parameter int ROW_IDX_SIZE = 16
);
  logic [ROW_LEN_SIZE*CHANNEL_NUM-1:0] len_in;
  logic [CHANNEL_NUM-1:0]              len_empty;
  logic [CHANNEL_NUM-1:0]              len_read;
  logic [CHANNEL_NUM-1:0]              elem_valid;
  logic [CHANNEL_NUM-1:0]              elem_ready;
  logic [CHANNEL_NUM-1:0]              elem_last;
  logic [ROW_IDX_SIZE*CHANNEL_NUM-1:0] row_idx;
  logic [CHANNEL_NUM-1:0]              row_end;
  logic [CHANNEL_NUM-1:0]              row_zero;
  logic [CHANNEL_NUM-1:0]              done;

  modport master (
    input  len_in, len_empty, elem_ready,
    output len_read, elem_valid, elem_last, row_idx, row_end, row_zero, done
  );

  modport slave (
    output len_in, len_empty, elem_ready,
    input  len_read, elem_valid, elem_last, row_idx, row_end, row_zero, done
  );
endinterface

// File: rtl/row_sequencer.sv
// Per-channel expansion of row lengths into element requests, with row-end /
// empty-row events for the accumulator. Channels are fully independent.
//
// state  | meaning
// S_IDLE | pop next length when the FIFO is not empty
// S_WAIT | FIFO data valid, load remaining count
// S_RUN  | issue element requests until the last one is accepted
// S_END  | one-cycle row_end (row_zero for empty rows), advance row index
// S_DONE | NUM_ROWS rows finished, channel parked until reset
module row_sequencer #(
  parameter int CHANNEL_NUM  = 8,
  parameter int ROW_LEN_SIZE = 9,
  parameter int ROW_IDX_SIZE = 16,
  parameter int NUM_ROWS     = 64
) (
  input logic           clk,
  input logic           rst,
  row_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RUN,
    S_END,
    S_DONE
  } state_t;

  localparam logic [ROW_IDX_SIZE-1:0] LAST_ROW_IDX = ROW_IDX_SIZE'(NUM_ROWS);
  localparam logic [ROW_LEN_SIZE-1:0] REM_ONE      = ROW_LEN_SIZE'(1);

  for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_ch
    state_t                  r_state;
    state_t                  w_next;
    logic [ROW_LEN_SIZE-1:0] r_rem;
    logic                    r_zero;
    logic [ROW_IDX_SIZE-1:0] r_row_idx;
    logic [ROW_LEN_SIZE-1:0] w_len;
    logic [ROW_IDX_SIZE-1:0] w_idx_inc;
    logic                    w_hs;

    assign w_len     = bus.len_in[i*ROW_LEN_SIZE +: ROW_LEN_SIZE];
    assign w_idx_inc = r_row_idx + ROW_IDX_SIZE'(1);
    assign w_hs      = (r_state == S_RUN) && bus.elem_ready[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= S_IDLE;
        r_rem     <= '0;
        r_zero    <= 1'b0;
        r_row_idx <= '0;
      end else begin
        r_state <= w_next;
        case (r_state)
          S_WAIT: begin
            r_rem  <= w_len;
            r_zero <= (w_len == '0);
          end
          S_RUN: begin
            if (w_hs && (r_rem != '0)) r_rem <= r_rem - REM_ONE;
          end
          S_END: r_row_idx <= w_idx_inc;
          default: ;
        endcase
      end
    end

    always_comb begin
      w_next = r_state;
      case (r_state)
        S_IDLE: if (!bus.len_empty[i]) w_next = S_WAIT;
        S_WAIT: w_next = (w_len == '0) ? S_END : S_RUN;
        S_RUN:  if (w_hs && (r_rem == REM_ONE)) w_next = S_END;
        S_END:  w_next = (w_idx_inc == LAST_ROW_IDX) ? S_DONE : S_IDLE;
        S_DONE: w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end

    // rst gate keeps the read strobe quiet while reset is held
    assign bus.len_read[i]   = (r_state == S_IDLE) && !bus.len_empty[i] && !rst;
    assign bus.elem_valid[i] = (r_state == S_RUN);
    assign bus.elem_last[i]  = (r_state == S_RUN) && (r_rem == REM_ONE);
    assign bus.row_end[i]    = (r_state == S_END);
    assign bus.row_zero[i]   = (r_state == S_END) && r_zero;
    assign bus.done[i]       = (r_state == S_DONE);
    assign bus.row_idx[i*ROW_IDX_SIZE +: ROW_IDX_SIZE] = r_row_idx;
  end

endmodule

// File: tb/tb_row_sequencer.sv
// Directed bench for row_sequencer: FIFO model per channel, handshake and
// row-end counters, hand-computed expectations at each step.
module tb_row_sequencer;
  localparam int CH = 8;
  localparam int LW = 9;
  localparam int IW = 16;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  row_sequencer_if #(.CHANNEL_NUM(CH), .ROW_LEN_SIZE(LW), .ROW_IDX_SIZE(IW)) bus ();

  row_sequencer #(
    .CHANNEL_NUM(CH), .ROW_LEN_SIZE(LW), .ROW_IDX_SIZE(IW), .NUM_ROWS(NR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [LW-1:0] fq   [CH][8];
  logic [LW-1:0] dout [CH] = '{default: '0};
  int head   [CH] = '{default: 0};
  int tail   [CH] = '{default: 0};
  int hs_cnt [CH] = '{default: 0};
  int re_cnt [CH] = '{default: 0};
  int hs_base[CH];
  int re_base;

  always_comb begin
    bus.len_in    = '0;
    bus.len_empty = '0;
    for (int i = 0; i < CH; i++) begin
      bus.len_empty[i]         = (head[i] == tail[i]);
      bus.len_in[i*LW +: LW]   = dout[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (flush) head[i] <= tail[i];
      else if (bus.len_read[i]) begin
        dout[i] <= fq[i][head[i] % 8];
        head[i] <= head[i] + 1;
      end
      if (bus.elem_valid[i] && bus.elem_ready[i]) hs_cnt[i] <= hs_cnt[i] + 1;
      if (bus.row_end[i]) re_cnt[i] <= re_cnt[i] + 1;
    end
  end

  task automatic push(input int ch, input int len);
    fq[ch][tail[ch] % 8] = len[LW-1:0];
    tail[ch] = tail[ch] + 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic all_quiet(input string tag);
    chk({tag, "_len_read"}, bus.len_read, 0);
    chk({tag, "_valid"}, bus.elem_valid, 0);
    chk({tag, "_last"}, bus.elem_last, 0);
    chk({tag, "_row_end"}, bus.row_end, 0);
    chk({tag, "_row_zero"}, bus.row_zero, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_row_idx_lo"}, bus.row_idx[63:0], 0);
    chk({tag, "_row_idx_hi"}, bus.row_idx[127:64], 0);
  endtask

  initial begin
    logic [CH-1:0] exp_valid, exp_end;
    rst = 1'b1;
    bus.elem_ready = '0;
    repeat (3) @(negedge clk);
    all_quiet("reset");
    rst = 1'b0;
    #1 all_quiet("post_reset");
    @(negedge clk);

    // len=3 on channel 0, ready held high
    bus.elem_ready = '1;
    push(0, 3);
    #1 chk("t1_read", bus.len_read, 8'h01);
    @(negedge clk) chk("t1_wait_valid", bus.elem_valid, 8'h00);
    chk("t1_wait_read", bus.len_read, 8'h00);
    @(negedge clk) chk("t1_v2", bus.elem_valid, 8'h01); chk("t1_l2", bus.elem_last, 8'h00);
    @(negedge clk) chk("t1_v3", bus.elem_valid, 8'h01); chk("t1_l3", bus.elem_last, 8'h00);
    @(negedge clk) chk("t1_v4", bus.elem_valid, 8'h01); chk("t1_l4", bus.elem_last, 8'h01);
    @(negedge clk) chk("t1_end", bus.row_end, 8'h01); chk("t1_zero", bus.row_zero, 8'h00);
    chk("t1_idx_end", bus.row_idx[IW-1:0], 0); chk("t1_v5", bus.elem_valid, 8'h00);
    @(negedge clk) chk("t1_end_gone", bus.row_end, 8'h00);
    chk("t1_idx_inc", bus.row_idx[IW-1:0], 1); chk("t1_hs", hs_cnt[0], 3);

    // empty row on channel 2
    push(2, 0);
    #1 chk("t2_read", bus.len_read, 8'h04);
    @(negedge clk) chk("t2_wait_end", bus.row_end, 8'h00); chk("t2_wait_v", bus.elem_valid, 8'h00);
    @(negedge clk) chk("t2_end", bus.row_end, 8'h04); chk("t2_zero", bus.row_zero, 8'h04);
    chk("t2_v", bus.elem_valid, 8'h00); chk("t2_idx_end", bus.row_idx[2*IW +: IW], 0);
    @(negedge clk) chk("t2_end_gone", bus.row_end, 8'h00);
    chk("t2_idx_inc", bus.row_idx[2*IW +: IW], 1); chk("t2_hs", hs_cnt[2], 0);

    // len=2 on channel 1 with a 4-cycle stall
    bus.elem_ready[1] = 1'b0;
    push(1, 2);
    #1 chk("t3_read", bus.len_read, 8'h02);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_stall_v", bus.elem_valid, 8'h02);
      chk("t3_stall_l", bus.elem_last, 8'h00);
      chk("t3_stall_hs", hs_cnt[1], 0);
    end
    @(negedge clk) chk("t3_v6", bus.elem_valid, 8'h02); chk("t3_l6", bus.elem_last, 8'h00);
    bus.elem_ready[1] = 1'b1;
    @(negedge clk) chk("t3_v7", bus.elem_valid, 8'h02); chk("t3_l7", bus.elem_last, 8'h02);
    chk("t3_hs1", hs_cnt[1], 1);
    @(negedge clk) chk("t3_end", bus.row_end, 8'h02); chk("t3_hs2", hs_cnt[1], 2);
    chk("t3_v8", bus.elem_valid, 8'h00);
    @(negedge clk) chk("t3_idx_inc", bus.row_idx[IW +: IW], 1);

    // channel 0 second row reaches NUM_ROWS; third length stays in the FIFO
    push(0, 1);
    push(0, 5);
    #1 chk("t4_read", bus.len_read, 8'h01);
    @(negedge clk);
    @(negedge clk) chk("t4_v", bus.elem_valid, 8'h01); chk("t4_l", bus.elem_last, 8'h01);
    @(negedge clk) chk("t4_end", bus.row_end, 8'h01); chk("t4_not_done", bus.done, 8'h00);
    @(negedge clk) chk("t4_done", bus.done, 8'h01); chk("t4_no_read", bus.len_read, 8'h00);
    chk("t4_not_empty", bus.len_empty[0], 1'b0); chk("t4_idx", bus.row_idx[IW-1:0], 2);
    repeat (3) @(negedge clk);
    chk("t4_done_hold", bus.done, 8'h01); chk("t4_read_hold", bus.len_read, 8'h00);
    chk("t4_v_hold", bus.elem_valid, 8'h00); chk("t4_pops", head[0], 2);

    // all channels, lengths 1..8 in parallel
    flush = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rst = 1'b0;
    #1 all_quiet("t5_reset");
    for (int i = 0; i < CH; i++) begin
      push(i, i + 1);
      hs_base[i] = hs_cnt[i];
    end
    #1 chk("t5_read", bus.len_read, 8'hFF);
    for (int off = 1; off <= 12; off++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        exp_valid[i] = (off >= 2) && (off <= i + 2);
        exp_end[i]   = (off == i + 3);
      end
      chk("t5_valid", bus.elem_valid, exp_valid);
      chk("t5_end", bus.row_end, exp_end);
    end
    for (int i = 0; i < CH; i++) begin
      chk("t5_hs", hs_cnt[i] - hs_base[i], i + 1);
      chk("t5_idx", bus.row_idx[i*IW +: IW], 1);
    end

    // reset in the middle of a row on channel 3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(3, 6);
    push(3, 2);
    #1 chk("t6_read", bus.len_read, 8'h08);
    repeat (4) @(negedge clk);
    chk("t6_run_v", bus.elem_valid, 8'h08); chk("t6_run_l", bus.elem_last, 8'h00);
    re_base = re_cnt[3];
    rst = 1'b1;
    #1 all_quiet("t6_in_reset");
    @(negedge clk) all_quiet("t6_held");
    rst = 1'b0;
    #1 chk("t6_restart_read", bus.len_read, 8'h08);
    chk("t6_restart_idx", bus.row_idx[3*IW +: IW], 0);
    @(negedge clk);
    @(negedge clk) chk("t6_v", bus.elem_valid, 8'h08); chk("t6_l", bus.elem_last, 8'h00);
    @(negedge clk) chk("t6_l2", bus.elem_last, 8'h08);
    @(negedge clk) chk("t6_end", bus.row_end, 8'h08); chk("t6_idx_end", bus.row_idx[3*IW +: IW], 0);
    chk("t6_no_abandoned_end", re_cnt[3] - re_base, 0);
    @(negedge clk) chk("t6_one_end", re_cnt[3] - re_base, 1);

    // maximum row length on channel 5
    hs_base[5] = hs_cnt[5];
    push(5, 511);
    repeat (512) @(negedge clk);
    chk("t7_v", bus.elem_valid, 8'h20); chk("t7_l", bus.elem_last, 8'h20);
    chk("t7_hs_pre", hs_cnt[5] - hs_base[5], 510);
    @(negedge clk) chk("t7_end", bus.row_end, 8'h20); chk("t7_hs", hs_cnt[5] - hs_base[5], 511);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
